// File: rtl/arbiter_8x1_32bit_if.sv
// Request/grant and output-word bundle shared by arbiter_8x1_32bit and its consumer.
// master drives requests and ready; slave is the arbiter.
interface arbiter_8x1_32bit_if #(
   parameter int DATA_W = 32
);
   logic [7:0]          req;
   logic [8*DATA_W-1:0] data_in;
   logic [7:0]          grant;
   logic [2:0]          out_sel;
   logic [DATA_W-1:0]   out_data;
   logic                out_valid;
   logic                out_ready;

   modport master (
      output req, data_in, out_ready,
      input  grant, out_sel, out_data, out_valid
   );

   modport slave (
      input  req, data_in, out_ready,
      output grant, out_sel, out_data, out_valid
   );
endinterface

// File: rtl/arbiter_8x1_32bit.sv
// 8-requester arbiter capturing the winner's word through a single 8x1 mux into a held output.
// Define ARB_ROUND_ROBIN_EN for round-robin arbitration; default is fixed lowest-index priority.
module arbiter_8x1_32bit #(
   parameter int DATA_W = 32
) (
   input logic                clk,
   input logic                rst_n,
   arbiter_8x1_32bit_if.slave bus
);
   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_BUSY = 1'b1;

   logic [0:0]        r_state;
   logic [7:0]        r_grant;
   logic [2:0]        r_sel;
   logic [DATA_W-1:0] r_data;
   logic              r_valid;

   logic [2:0]        w_winner;
   logic [DATA_W-1:0] w_mux_data;
   logic              w_capture;
   logic              w_handshake;

   assign w_capture   = (r_state == ST_IDLE) && (|bus.req);
   assign w_handshake = (r_state == ST_BUSY) && r_valid && bus.out_ready;

`ifdef ARB_ROUND_ROBIN_EN
   logic [2:0] r_ptr;

   // Scan downward so the last hit is the first set bit at or after the pointer.
   always_comb begin
      // NOTE: default assignment first so every path drives w_winner and no latch is inferred.
      w_winner = r_ptr;
      for (int k = 7; k >= 0; k--) begin
         if (bus.req[r_ptr + 3'(k)]) w_winner = r_ptr + 3'(k);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)           r_ptr <= 3'd0;
      else if (w_handshake) r_ptr <= r_sel + 3'd1;
   end
`else
   always_comb begin
      w_winner = 3'd0;
      for (int k = 7; k >= 0; k--) begin
         if (bus.req[3'(k)]) w_winner = 3'(k);
      end
   end
`endif

   // The only data path: one 8x1 mux steered by the arbitration result.
   assign w_mux_data = bus.data_in[w_winner*DATA_W +: DATA_W];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_grant <= 8'd0;
         r_sel   <= 3'd0;
         r_data  <= '0;
         r_valid <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every register updates from pre-edge values.
         r_grant <= 8'd0;
         case (r_state)
            ST_IDLE: begin
               if (w_capture) begin
                  r_sel   <= w_winner;
                  r_data  <= w_mux_data;
                  r_valid <= 1'b1;
                  r_grant <= 8'd1 << w_winner;
                  r_state <= ST_BUSY;
               end
            end
            ST_BUSY: begin
               if (w_handshake) begin
                  r_valid <= 1'b0;
                  r_state <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign bus.grant     = r_grant;
   assign bus.out_sel   = r_sel;
   assign bus.out_data  = r_data;
   assign bus.out_valid = r_valid;
endmodule

// File: tb/tb_arbiter_8x1_32bit.sv
// Self-checking bench for arbiter_8x1_32bit: directed scenarios plus random traffic against a
// transaction-level reference model; follows ARB_ROUND_ROBIN_EN the same way as the design.
module tb_arbiter_8x1_32bit;
`ifdef ARB_ROUND_ROBIN_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   logic clk;
   logic rst_n;
   int   checks;
   int   failures;

   arbiter_8x1_32bit_if #(.DATA_W(32)) bus ();

   arbiter_8x1_32bit #(.DATA_W(32)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: is a word pending, whose word, which requester, what pointer.
   bit          m_busy;
   int          m_idx;
   logic [31:0] m_word;
   logic [7:0]  m_grant;
   int          m_ptr;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // First set request starting at p (round-robin) or at 0 (fixed priority).
   function automatic int pick(input logic [7:0] r, input int p);
      for (int k = 0; k < 8; k++) begin
         int idx;
         idx = RR ? (p + k) % 8 : k;
         if (r[idx]) return idx;
      end
      return 0;
   endfunction

   task automatic model_reset();
      m_busy  = 1'b0;
      m_idx   = 0;
      m_word  = 32'd0;
      m_grant = 8'd0;
      m_ptr   = 0;
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_grant"},     32'(bus.grant),     32'd0);
      check({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
      check({tag, "_out_sel"},   32'(bus.out_sel),   32'd0);
      check({tag, "_out_data"},  bus.out_data,       32'd0);
   endtask

   // Asynchronous reset pulse, checked before any clock edge can occur.
   task automatic pulse_reset(input string tag);
      #2;
      rst_n = 1'b0;
      #1;
      check_zero(tag);
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // Advance one clock: predict from the inputs now applied, then compare just after the edge.
   task automatic cycle(input string tag);
      m_grant = 8'd0;
      if (m_busy) begin
         if (bus.out_ready) begin
            m_busy = 1'b0;
            if (RR) m_ptr = (m_idx + 1) % 8;
         end
      end else if (bus.req != 8'd0) begin
         m_idx   = pick(bus.req, m_ptr);
         m_word  = bus.data_in[m_idx*32 +: 32];
         m_busy  = 1'b1;
         m_grant = 8'(1 << m_idx);
      end
      @(posedge clk);
      #1;
      check({tag, "_grant"},     32'(bus.grant),           32'(m_grant));
      check({tag, "_out_valid"}, 32'(bus.out_valid),       32'(m_busy));
      check({tag, "_onehot0"},   32'($onehot0(bus.grant)), 32'd1);
      if (m_busy) begin
         check({tag, "_out_sel"},  32'(bus.out_sel), 32'(m_idx));
         check({tag, "_out_data"}, bus.out_data,     m_word);
      end
   endtask

   task automatic set_words_index_plus_one();
      for (int i = 0; i < 8; i++) bus.data_in[i*32 +: 32] = 32'(i + 1);
   endtask

   task automatic randomize_words();
      for (int i = 0; i < 8; i++) bus.data_in[i*32 +: 32] = $urandom;
   endtask

   initial begin
      checks        = 0;
      failures      = 0;
      rst_n         = 1'b0;
      bus.req       = 8'd0;
      bus.data_in   = '0;
      bus.out_ready = 1'b0;
      model_reset();

      // Reset state.
      repeat (2) @(posedge clk);
      #1;
      check_zero("reset");
      @(negedge clk);
      rst_n = 1'b1;

      // Idle with no requests and a stray ready: nothing happens.
      bus.out_ready = 1'b1;
      cycle("idle_noreq");
      cycle("idle_noreq2");

      // Single requester 0 with word 1.
      bus.data_in[31:0] = 32'd1;
      bus.req = 8'h01;
      cycle("single0_cap");
      check("single0_sel_direct", 32'(bus.out_sel), 32'd0);
      check("single0_data_direct", bus.out_data, 32'd1);
      bus.req = 8'h00;
      cycle("single0_hs");
      cycle("single0_idle");

      // All requesters held high, ready always high: capture/handshake alternate.
      pulse_reset("rst_before_all");
      set_words_index_plus_one();
      bus.req = 8'hFF;
      bus.out_ready = 1'b1;
      for (int i = 0; i < 18; i++) cycle("all_req");
      bus.req = 8'h00;
      cycle("all_req_drain");
      cycle("all_req_drain2");

      // Requester 7 alone after reset, then 7 and 0 together.
      pulse_reset("rst_before_top");
      bus.req = 8'h80;
      cycle("top7_cap");
      check("top7_data_direct", bus.out_data, 32'd8);
      bus.req = 8'h00;
      cycle("top7_hs");
      bus.req = 8'h81;
      cycle("wrap_cap");
      check("wrap_sel_direct", 32'(bus.out_sel), 32'd0);
      bus.req = 8'h00;
      cycle("wrap_hs");

      // Winner 3 stalled for five cycles while inputs churn.
      bus.out_ready = 1'b0;
      bus.req = 8'h08;
      cycle("stall_cap");
      for (int i = 0; i < 5; i++) begin
         bus.req = 8'($urandom);
         randomize_words();
         cycle("stall_hold");
         check("stall_sel_direct", 32'(bus.out_sel), 32'd3);
         check("stall_data_direct", bus.out_data, 32'd4);
      end
      bus.req = 8'h00;
      bus.out_ready = 1'b1;
      cycle("stall_release");
      cycle("stall_idle");

      // Reset while a word is pending, then requesters 1 and 2 arbitrate from pointer 0.
      set_words_index_plus_one();
      bus.out_ready = 1'b0;
      bus.req = 8'h20;
      cycle("busy_cap");
      bus.req = 8'h00;
      pulse_reset("rst_mid_busy");
      bus.req = 8'h06;
      cycle("post_rst_cap");
      check("post_rst_sel_direct", 32'(bus.out_sel), 32'd1);
      bus.req = 8'h00;
      bus.out_ready = 1'b1;
      cycle("post_rst_hs");

      // Random traffic.
      for (int i = 0; i < 400; i++) begin
         bus.req = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'd0;
         randomize_words();
         bus.out_ready = 1'($urandom_range(0, 1));
         cycle("random");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/arbiter_8x1_32bit.md
ARBITER_8X1_32BIT -- requirements
Module: arbiter_8x1_32bit

Interface
REQ-001 Parameter: DATA_W, 32, width of each requester data word and of out_data.
REQ-002 Port: clk  input  1  single clock, all state updates on rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Port: req  input  8  request per requester; bit i = requester i (i=0..7, index matches mux select value).
REQ-005 Port: data_in  input  8*DATA_W  requester words packed; requester i at bits [i*DATA_W +: DATA_W].
REQ-006 Port: grant  output  8  one-hot, one-cycle pulse acknowledging the captured requester.
REQ-007 Port: out_sel  output  3  binary index of current winner, drives the 8x1 mux select.
REQ-008 Port: out_data  output  DATA_W  registered word of current winner.
REQ-009 Port: out_valid  output  1  out_data/out_sel valid.
REQ-010 Port: out_ready  input  1  consumer accepts out_data when out_valid and out_ready are both high.

Function
REQ-011 Block SHALL contain one 8x1 DATA_W mux selecting data_in word by a 3-bit select; no other data path.
REQ-012 FSM SHALL have two states: IDLE and BUSY.
REQ-013 IDLE, req==0: SHALL stay IDLE; grant, out_valid held 0.
REQ-014 IDLE, req!=0 at edge N: SHALL pick winner w by arbitration, load out_sel=w, out_data=data_in word w, assert out_valid, pulse grant[w] for exactly the cycle after edge N, enter BUSY.
REQ-015 Latency: req sampled at edge N -> grant, out_valid, out_data visible after edge N (one cycle).
REQ-016 BUSY: out_data, out_sel, out_valid SHALL hold stable until handshake; req and data_in changes SHALL be ignored.
REQ-017 BUSY with out_valid && out_ready at edge M: SHALL clear out_valid, update priority pointer, return to IDLE; new arbitration earliest at edge M+1 (max one transfer per two cycles).
REQ-018 Requester SHALL drop req after seeing grant; req still high in IDLE is treated as a new request.
REQ-019 Round-robin: pointer p (3-bit); winner = first set req bit scanning p, p+1, ... wrapping 7->0.
REQ-020 After handshake with winner w, p SHALL become (w+1) mod 8; w=7 wraps p to 0.
REQ-021 Single requester SHALL win regardless of p.
REQ-022 grant SHALL never have more than one bit set; out_sel SHALL equal index of that bit.
REQ-023 out_ready while out_valid=0 SHALL have no effect.

Reset
REQ-024 rst_n low SHALL immediately force: state IDLE, grant=0, out_valid=0, out_sel=0, out_data=0, p=0.
REQ-025 Reset in BUSY SHALL discard pending word without handshake; first arbitration after release uses p=0.

Configuration
REQ-026 Macro ARB_ROUND_ROBIN_EN defined: arbitration per REQ-019..REQ-020.
REQ-027 Macro undefined: fixed priority, lowest set index wins, p not implemented; all other behaviour identical.

Verification
REQ-028 req=8'b0000_0001, word0=32'd1, out_ready=1 -> next cycle grant=8'h01, out_sel=0, out_data=1, out_valid=1; IDLE after handshake.
REQ-029 req=8'hFF held, words i=i+1, out_ready=1, RR on -> winners 0,1,2,...,7,0 with out_data 1..8,1; fixed priority -> always 0.
REQ-030 req=8'h80 after reset (p=0) -> winner 7, out_data=32'd8, then p wraps to 0; next req=8'h81 -> winner 0.
REQ-031 Winner 3 captured, out_ready=0 for 5 cycles while req and data_in change -> out_data, out_sel=3, out_valid stable; then out_ready=1 -> out_valid low next cycle.
REQ-032 rst_n pulsed low mid-BUSY -> outputs zero asynchronously; after release req=8'h06 -> winner 1.
REQ-033 Every cycle: grant one-hot or zero, grant high only in the cycle following IDLE capture.
